// File: rtl/popcount_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// popcount_pkg
//   Shared types and constants for the popcount sequencer slice.
//   - NIBBLE_W            : width of the chunk fed through the shared LUT
//   - DEFAULT_DATA_WIDTH  : default input word width
//   - pc_state_t          : sequencer FSM states
//   - count_w()           : width needed to hold a bit count of a word
// ---------------------------------------------------------------------------
package popcount_pkg;

  localparam int NIBBLE_W           = 4;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pc_state_t;

  // A word of dw bits has between 0 and dw ones, i.e. dw+1 distinct values.
  function automatic int count_w(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/popcount_sequencer_if.sv
// ---------------------------------------------------------------------------
// popcount_sequencer_if
//   Valid/ready word input channel plus valid/ready count output channel.
//   Ports (signals):
//     in_valid, in_data[DATA_WIDTH], out_ready : producer/consumer -> block
//     in_ready, out_valid, out_count[COUNT_W]  : block -> producer/consumer
//   Modports:
//     master : the side that supplies words and takes counts
//     slave  : the popcount sequencer itself
// ---------------------------------------------------------------------------
interface popcount_sequencer_if
  import popcount_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  localparam int COUNT_W = count_w(DATA_WIDTH);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [COUNT_W-1:0]    out_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count
  );

endinterface

// File: rtl/popcount_sequencer_lut.sv
// ---------------------------------------------------------------------------
// nibble_popcount_lut
//   Purely combinational 4-bit popcount table.
//   Ports:
//     nibble [3:0] in  : value to count
//     ones   [2:0] out : number of set bits in nibble (0..4)
// ---------------------------------------------------------------------------
module nibble_popcount_lut
  import popcount_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [2:0]          ones
);

  always_comb begin
    ones = 3'd0;
    case (nibble)
      4'h0: ones = 3'd0;
      4'h1: ones = 3'd1;
      4'h2: ones = 3'd1;
      4'h3: ones = 3'd2;
      4'h4: ones = 3'd1;
      4'h5: ones = 3'd2;
      4'h6: ones = 3'd2;
      4'h7: ones = 3'd3;
      4'h8: ones = 3'd1;
      4'h9: ones = 3'd2;
      4'hA: ones = 3'd2;
      4'hB: ones = 3'd3;
      4'hC: ones = 3'd2;
      4'hD: ones = 3'd3;
      4'hE: ones = 3'd3;
      4'hF: ones = 3'd4;
      default: ones = 3'd0;
    endcase
  end

endmodule

// File: rtl/popcount_sequencer.sv
// ---------------------------------------------------------------------------
// popcount_sequencer
//   Counts the ones in a DATA_WIDTH-bit word by shifting it through a single
//   shared nibble popcount LUT, one nibble per clock, and accumulating.
//   Parameters:
//     DATA_WIDTH : word width, multiple of 4 and >= 4
//     EARLY_EXIT : 1 = stop as soon as the unprocessed remainder is zero
//   Ports:
//     clk   in  : single clock, rising edge
//     rst   in  : synchronous active-high reset, aborts any word in flight
//     bus   slave modport of popcount_sequencer_if (word in / count out)
//     busy  out : high while a word is being counted or its result is held
// ---------------------------------------------------------------------------
module popcount_sequencer
  import popcount_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  popcount_sequencer_if.slave         bus,
  output logic                        busy
);

  localparam int NIBBLES = DATA_WIDTH / NIBBLE_W;
  localparam int COUNT_W = count_w(DATA_WIDTH);
  // Keep the index at least one bit wide so a single-nibble word still works.
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  pc_state_t             state_reg, state_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [COUNT_W-1:0]    acc_reg, acc_next;
  logic [COUNT_W-1:0]    count_reg, count_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;

  logic [2:0]            lut_out;
  logic [COUNT_W-1:0]    acc_sum;
  logic [DATA_WIDTH-1:0] shift_down;
  logic                  last_nibble;

  nibble_popcount_lut u_lut (
    .nibble (shift_reg[NIBBLE_W-1:0]),
    .ones   (lut_out)
  );

  assign acc_sum    = acc_reg + COUNT_W'(lut_out);
  assign shift_down = shift_reg >> NIBBLE_W;
  // Early exit looks at what would remain after this nibble: if nothing is
  // left, the current sum is already the final count.
  assign last_nibble = (idx_reg == LAST_IDX) ||
                       (EARLY_EXIT && (shift_down == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      acc_reg   <= '0;
      count_reg <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      acc_reg   <= acc_next;
      count_reg <= count_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    acc_next   = acc_reg;
    count_next = count_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        // in_ready is exactly (state == IDLE), so in_valid alone is the accept.
        if (bus.in_valid) begin
          shift_next = bus.in_data;
          acc_next   = '0;
          idx_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        acc_next   = acc_sum;
        shift_next = shift_down;
        idx_next   = idx_reg + 1'b1;
        if (last_nibble) begin
          count_next = acc_sum;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.out_count = count_reg;
  assign busy          = (state_reg == RUN) || (state_reg == DONE);

endmodule
